// File: rtl/mlp_layer_ctrl_pkg.sv
// Shared constants and FSM encoding for the MLP layer sequencer.
package mlp_layer_ctrl_pkg;
  localparam int VEC_ELEMS = 62;
  localparam int ELEM_W    = 8;
  localparam int VEC_W     = VEC_ELEMS * ELEM_W;
  localparam int MAC_W     = 21;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_EVAL,
    ST_OUT,
    ST_DONE
  } state_t;
endpackage

// File: rtl/mlp_layer_ctrl_relu_quant.sv
// ReLU quantiser: 21-bit sign-magnitude MAC result to an 8-bit non-negative
// sign-magnitude activation (shift, then saturate to 127).
module relu_quant
  import mlp_layer_ctrl_pkg::*;
#(
  parameter int SHIFT = 7
) (
  input  logic [MAC_W-1:0] mac_out,
  output logic [7:0]       q
);
  logic [MAC_W-2:0] mag_shifted;

  always_comb begin
    mag_shifted = mac_out[MAC_W-2:0] >> SHIFT;
    q           = 8'h00;
    // Any negative value, including negative zero, clamps to 0.
    if (!mac_out[MAC_W-1]) begin
      q = (mag_shifted > (MAC_W-1)'(127)) ? 8'h7F : {1'b0, mag_shifted[6:0]};
    end
  end
endmodule

// File: rtl/mlp_layer_ctrl.sv
// Per-neuron sequencer for one fully-connected layer: fetch weight row, drive
// the external MAC, quantise, and stream one activation per neuron.
module mlp_layer_ctrl
  import mlp_layer_ctrl_pkg::*;
#(
  parameter int NUM_NEURONS = 10,
  parameter int SHIFT       = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [VEC_W-1:0] a_in,
  output logic             busy,
  output logic             done,
  output logic             w_rd,
  output logic [7:0]       w_addr,
  input  logic [VEC_W-1:0] w_rdata,
  output logic [VEC_W-1:0] mac_a,
  output logic [VEC_W-1:0] mac_w,
  input  logic [MAC_W-1:0] mac_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [7:0]       out_idx
);
  localparam logic [7:0] LAST_N = 8'(NUM_NEURONS - 1);

  state_t           state_reg;
  logic [7:0]       n_reg;
  logic [VEC_W-1:0] a_reg;
  logic [VEC_W-1:0] w_reg;
  logic [7:0]       q_next;

  relu_quant #(.SHIFT(SHIFT)) u_quant (
    .mac_out (mac_out),
    .q       (q_next)
  );

  assign mac_a = a_reg;
  assign mac_w = w_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      n_reg     <= 8'd0;
      a_reg     <= '0;
      w_reg     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      w_rd      <= 1'b0;
      w_addr    <= 8'd0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      out_idx   <= 8'd0;
    end else begin
      // w_rd and done are single-cycle pulses raised on state entry.
      w_rd <= 1'b0;
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            a_reg     <= a_in;
            n_reg     <= 8'd0;
            w_addr    <= 8'd0;
            w_rd      <= 1'b1;
            busy      <= 1'b1;
            state_reg <= ST_FETCH;
          end
        end
        ST_FETCH: state_reg <= ST_WAIT;
        ST_WAIT: begin
          w_reg     <= w_rdata;
          state_reg <= ST_EVAL;
        end
        ST_EVAL: begin
          out_data  <= q_next;
          out_idx   <= n_reg;
          out_valid <= 1'b1;
          state_reg <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (n_reg == LAST_N) begin
              done      <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              n_reg     <= n_reg + 8'd1;
              w_addr    <= n_reg + 8'd1;
              w_rd      <= 1'b1;
              state_reg <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mlp_layer_ctrl.sv
// Directed bench: DUT a (3 neurons, SHIFT=0) and DUT b (10 neurons, SHIFT=7),
// each with a 1-cycle weight memory and a stub MAC returning mac_w[20:0].
module tb_mlp_layer_ctrl;
  import mlp_layer_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic             start_a = 1'b0, out_ready_a = 1'b0;
  logic [VEC_W-1:0] a_in_a = '0, w_rdata_a = '0, mac_a_a, mac_w_a;
  logic             busy_a, done_a, w_rd_a, out_valid_a;
  logic [7:0]       w_addr_a, out_data_a, out_idx_a;
  logic [MAC_W-1:0] mac_out_a;

  logic             start_b = 1'b0, out_ready_b = 1'b0;
  logic [VEC_W-1:0] a_in_b = '0, w_rdata_b = '0, mac_a_b, mac_w_b;
  logic             busy_b, done_b, w_rd_b, out_valid_b;
  logic [7:0]       w_addr_b, out_data_b, out_idx_b;
  logic [MAC_W-1:0] mac_out_b;

  logic [VEC_W-1:0] mem_a [256];
  logic [VEC_W-1:0] mem_b [256];
  logic [7:0]       exp_b [10];
  logic [VEC_W-1:0] p1, p2;

  assign mac_out_a = mac_w_a[MAC_W-1:0];
  assign mac_out_b = mac_w_b[MAC_W-1:0];

  always @(posedge clk) if (w_rd_a) w_rdata_a <= mem_a[w_addr_a];
  always @(posedge clk) if (w_rd_b) w_rdata_b <= mem_b[w_addr_b];

  mlp_layer_ctrl #(.NUM_NEURONS(3), .SHIFT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .a_in(a_in_a), .busy(busy_a),
    .done(done_a), .w_rd(w_rd_a), .w_addr(w_addr_a), .w_rdata(w_rdata_a),
    .mac_a(mac_a_a), .mac_w(mac_w_a), .mac_out(mac_out_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_data(out_data_a), .out_idx(out_idx_a)
  );

  mlp_layer_ctrl #(.NUM_NEURONS(10), .SHIFT(7)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .a_in(a_in_b), .busy(busy_b),
    .done(done_b), .w_rd(w_rd_b), .w_addr(w_addr_b), .w_rdata(w_rdata_b),
    .mac_a(mac_a_b), .mac_w(mac_w_b), .mac_out(mac_out_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_data(out_data_b), .out_idx(out_idx_b)
  );

  function automatic logic [VEC_W-1:0] row(input logic s, input logic [19:0] m);
    logic [VEC_W-1:0] r;
    r = '0;
    r[MAC_W-1:0] = {s, m};
    r[VEC_W-1 -: 8] = 8'hC3;
    return r;
  endfunction

  task automatic setup;
    for (int i = 0; i < 256; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    mem_a[0] = row(1'b0, 20'd5);
    mem_a[1] = row(1'b0, 20'd300);
    mem_a[2] = row(1'b0, 20'd0);
    mem_b[0] = row(1'b0, 20'd12800);   exp_b[0] = 8'h64;
    mem_b[1] = row(1'b1, 20'd0);       exp_b[1] = 8'h00;
    mem_b[2] = row(1'b0, 20'd16383);   exp_b[2] = 8'h7F;
    mem_b[3] = row(1'b0, 20'd16384);   exp_b[3] = 8'h7F;
    mem_b[4] = row(1'b0, 20'd255);     exp_b[4] = 8'h01;
    mem_b[5] = row(1'b0, 20'd128);     exp_b[5] = 8'h01;
    mem_b[6] = row(1'b0, 20'd127);     exp_b[6] = 8'h00;
    mem_b[7] = row(1'b1, 20'd1000);    exp_b[7] = 8'h00;
    mem_b[8] = row(1'b0, 20'd0);       exp_b[8] = 8'h00;
    mem_b[9] = row(1'b0, 20'hFFFFF);   exp_b[9] = 8'h7F;
    for (int i = 0; i < VEC_ELEMS; i++) p1[8*i +: 8] = 8'(i + 1);
    p2 = ~p1;
  endtask

  // Start is sampled by the edge that ends this task; returns at cycle 1 (+1).
  task automatic pulse_start_b(input logic [VEC_W-1:0] a);
    repeat (2) @(negedge clk);
    a_in_b = a; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy_a, done_a, w_rd_a, w_addr_a, out_valid_a, out_data_a, out_idx_a} !== 28'd0) begin
      n_bad++; $display("FAIL reset_ctrl_a: got %h want 0", {busy_a, done_a, w_rd_a, w_addr_a, out_valid_a, out_data_a, out_idx_a});
    end
    n_cmp++;
    if ({busy_b, done_b, w_rd_b, w_addr_b, out_valid_b, out_data_b, out_idx_b} !== 28'd0) begin
      n_bad++; $display("FAIL reset_ctrl_b: got %h want 0", {busy_b, done_b, w_rd_b, w_addr_b, out_valid_b, out_data_b, out_idx_b});
    end
    n_cmp++;
    if ((mac_a_b | mac_w_b | mac_a_a | mac_w_a) !== '0) begin
      n_bad++; $display("FAIL reset_mac_vectors: got nonzero want 0");
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_stream_a;
    logic [7:0] ed [3];
    ed[0] = 8'h05; ed[1] = 8'h7F; ed[2] = 8'h00;
    out_ready_a = 1'b1;
    @(negedge clk);
    a_in_a = p1; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      logic ev;
      ev = (c == 4 || c == 8 || c == 12);
      n_cmp++;
      if (out_valid_a !== ev) begin n_bad++; $display("FAIL stream_valid c%0d: got %b want %b", c, out_valid_a, ev); end
      n_cmp++;
      if (done_a !== (c == 13)) begin n_bad++; $display("FAIL stream_done c%0d: got %b want %b", c, done_a, (c == 13)); end
      n_cmp++;
      if (busy_a !== (c <= 13)) begin n_bad++; $display("FAIL stream_busy c%0d: got %b want %b", c, busy_a, (c <= 13)); end
      n_cmp++;
      if (w_rd_a !== (c == 1 || c == 5 || c == 9)) begin n_bad++; $display("FAIL stream_wrd c%0d: got %b", c, w_rd_a); end
      if (c == 1 || c == 5 || c == 9) begin
        n_cmp++;
        if (w_addr_a !== 8'((c - 1) / 4)) begin n_bad++; $display("FAIL stream_waddr c%0d: got %0d want %0d", c, w_addr_a, (c - 1) / 4); end
      end
      if (ev) begin
        n_cmp++;
        if (out_data_a !== ed[c/4-1] || out_idx_a !== 8'(c/4-1)) begin
          n_bad++; $display("FAIL stream_data c%0d: got %h/%0d want %h/%0d", c, out_data_a, out_idx_a, ed[c/4-1], c/4-1);
        end
        $display("stream_a: c%0d idx %0d data %h", c, out_idx_a, out_data_a);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_quant_b;
    int cnt;
    bit seen;
    cnt = 0; seen = 0;
    out_ready_b = 1'b1;
    pulse_start_b(p1);
    for (int c = 1; c <= 50; c++) begin
      if (out_valid_b && cnt < 10) begin
        n_cmp++;
        if (out_data_b !== exp_b[cnt] || out_idx_b !== 8'(cnt)) begin
          n_bad++; $display("FAIL quant_data n%0d: got %h/%0d want %h/%0d", cnt, out_data_b, out_idx_b, exp_b[cnt], cnt);
        end
        $display("quant_b: c%0d idx %0d data %h", c, out_idx_b, out_data_b);
        cnt++;
      end
      if (done_b) begin
        n_cmp++;
        if (c != 41) begin n_bad++; $display("FAIL quant_done_cycle: got %0d want 41", c); end
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (!seen || cnt != 10) begin n_bad++; $display("FAIL quant_count: got %0d done=%0d want 10 done=1", cnt, seen); end
  endtask

  task automatic test_stall_b;
    bit found;
    found = 0;
    out_ready_b = 1'b0;
    pulse_start_b(p1);
    for (int c = 1; c <= 10; c++) begin
      if (out_valid_b) begin
        found = 1;
        n_cmp++;
        if (c != 4) begin n_bad++; $display("FAIL stall_first_valid: got c%0d want c4", c); end
        break;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL stall_timeout: got no out_valid want out_valid"); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid_b, out_data_b, out_idx_b, w_rd_b} !== {1'b1, 8'h64, 8'd0, 1'b0}) begin
        n_bad++; $display("FAIL stall_hold k%0d: got v%b d%h i%0d rd%b want v1 d64 i0 rd0", k, out_valid_b, out_data_b, out_idx_b, w_rd_b);
      end
    end
    out_ready_b = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid_b, w_rd_b, w_addr_b} !== {1'b0, 1'b1, 8'd1}) begin
      n_bad++; $display("FAIL stall_release: got v%b rd%b a%0d want v0 rd1 a1", out_valid_b, w_rd_b, w_addr_b);
    end
    $display("stall_b: handshake after 5 stall cycles");
    found = 0;
    for (int c = 0; c < 60; c++) begin
      if (done_b) begin found = 1; break; end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL stall_done_timeout: got no done want done"); end
  endtask

  task automatic test_ignore_start_b;
    int cnt;
    bit seen;
    cnt = 0; seen = 0;
    out_ready_b = 1'b1;
    pulse_start_b(p1);
    for (int c = 1; c <= 50; c++) begin
      if (out_valid_b && cnt < 10) begin
        n_cmp++;
        if (out_data_b !== exp_b[cnt] || out_idx_b !== 8'(cnt)) begin
          n_bad++; $display("FAIL ignore_data n%0d: got %h/%0d want %h/%0d", cnt, out_data_b, out_idx_b, exp_b[cnt], cnt);
        end
        cnt++;
      end
      if (c == 3 || c == 7) begin
        n_cmp++;
        if (mac_a_b !== p1) begin n_bad++; $display("FAIL ignore_areg c%0d: got %h want %h", c, mac_a_b[31:0], p1[31:0]); end
      end
      if (done_b) begin
        n_cmp++;
        if (c != 41) begin n_bad++; $display("FAIL ignore_done_cycle: got %0d want 41", c); end
        seen = 1;
        break;
      end
      if (c == 2 || c == 6) begin a_in_b = p2; start_b = 1'b1; end
      else start_b = 1'b0;
      @(posedge clk); #1;
    end
    start_b = 1'b0;
    n_cmp++;
    if (!seen || cnt != 10 || mac_a_b !== p1) begin
      n_bad++; $display("FAIL ignore_summary: got cnt %0d done %0d want cnt 10 done 1 a_reg p1", cnt, seen);
    end
    $display("ignore_start_b: %0d outputs", cnt);
  endtask

  task automatic test_reset_mid_b;
    out_ready_b = 1'b1;
    pulse_start_b(p1);
    for (int c = 1; c < 15; c++) begin @(posedge clk); #1; end
    out_ready_b = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid_b, out_idx_b, out_data_b} !== {1'b1, 8'd3, 8'h7F}) begin
      n_bad++; $display("FAIL rstmid_pre: got v%b i%0d d%h want v1 i3 d7f", out_valid_b, out_idx_b, out_data_b);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy_b, done_b, w_rd_b, w_addr_b, out_valid_b, out_data_b, out_idx_b} !== 28'd0) begin
      n_bad++; $display("FAIL rstmid_ctrl: got %h want 0", {busy_b, done_b, w_rd_b, w_addr_b, out_valid_b, out_data_b, out_idx_b});
    end
    n_cmp++;
    if ((mac_a_b | mac_w_b) !== '0) begin n_bad++; $display("FAIL rstmid_mac: got nonzero want 0"); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready_b = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid_b, busy_b, w_rd_b} !== 3'b000) begin
        n_bad++; $display("FAIL rstmid_quiet k%0d: got v%b b%b rd%b want 000", k, out_valid_b, busy_b, w_rd_b);
      end
    end
    $display("reset_mid_b: idle after release");
  endtask

  initial begin
    setup();
    test_reset();
    test_stream_a();
    test_quant_b();
    test_stall_b();
    test_ignore_start_b();
    test_reset_mid_b();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
